// File: rtl/ddr2_port_arbiter.sv
// Two-port (write/read) arbiter in front of a single DDR2 controller port.
// Registered command outputs, run-length fairness, urgent-read priority, stall timeout.
module ddr2_port_arbiter #(
    parameter int MAX_RUN = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic        ctrl_clk,
    input  logic        reset,
    input  logic        wr_req,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_done,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    input  logic        rd_urgent,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic [31:0] mem_addr,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    input  logic [31:0] mem_rdata,
    input  logic        mem_waitrequest,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    localparam logic [4:0] RunMax  = 5'(MAX_RUN);
    localparam logic [9:0] WaitEnd = 10'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [4:0]  run_q, run_d;
    logic        last_rd_q, last_rd_d;
    logic [9:0]  wait_q, wait_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mwr_q, mwr_d;
    logic        mrd_q, mrd_d;
    logic        wdone_q, wdone_d;
    logic        rvalid_q, rvalid_d;
    logic        err_q, err_d;

    logic grant;
    logic pick_rd;
    logic active;
    logic finish;
    logic abort;

    // Arbitration decision, only meaningful while IDLE
    always_comb begin
        pick_rd = rd_req;
        if (wr_req && rd_req) begin
            if (rd_urgent)
                pick_rd = 1'b1;
            else if (run_q < RunMax)
                pick_rd = last_rd_q;
            else
                pick_rd = ~last_rd_q;
        end
    end

    assign grant  = (state_q == IDLE) && (wr_req || rd_req);
    assign active = (state_q == WRITE) || (state_q == READ);
    assign finish = active && !mem_waitrequest;
    assign abort  = active && mem_waitrequest && (wait_q == WaitEnd);

    always_ff @(posedge ctrl_clk) begin
        if (reset) begin
            state_q   <= IDLE;
            run_q     <= '0;
            last_rd_q <= 1'b0;
            wait_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            mwr_q     <= 1'b0;
            mrd_q     <= 1'b0;
            wdone_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            last_rd_q <= last_rd_d;
            wait_q    <= wait_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            mwr_q     <= mwr_d;
            mrd_q     <= mrd_d;
            wdone_q   <= wdone_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        last_rd_d = last_rd_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = pick_rd ? READ : WRITE;
                    if (pick_rd == last_rd_q) begin
                        run_d = (run_q >= RunMax) ? RunMax : run_q + 5'd1;
                    end else begin
                        run_d     = 5'd1;
                        last_rd_d = pick_rd;
                    end
                end
            end
            WRITE, READ: begin
                if (finish || abort)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        mwr_d    = 1'b0;
        mrd_d    = 1'b0;
        wdone_d  = 1'b0;
        rvalid_d = 1'b0;
        err_d    = err_q | abort;
        wait_d   = wait_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    wait_d = '0;
                    mwr_d  = ~pick_rd;
                    mrd_d  = pick_rd;
                    addr_d = pick_rd ? rd_addr : wr_addr;
                    if (!pick_rd)
                        wdata_d = wr_data;
                end
            end
            WRITE: begin
                mwr_d   = mem_waitrequest && !abort;
                wdone_d = !mem_waitrequest;
                if (mem_waitrequest)
                    wait_d = wait_q + 10'd1;
            end
            READ: begin
                mrd_d    = mem_waitrequest && !abort;
                rvalid_d = !mem_waitrequest;
                if (mem_waitrequest)
                    wait_d = wait_q + 10'd1;
                else
                    rdata_d = mem_rdata;
            end
            default: ;
        endcase
    end

    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_write   = mwr_q;
    assign mem_read    = mrd_q;
    assign wr_done     = wdone_q;
    assign rd_valid    = rvalid_q;
    assign rd_data     = rdata_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_ddr2_port_arbiter.sv
// Directed bench for ddr2_port_arbiter.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_ddr2_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_done;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_urgent;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [31:0] mem_addr;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic [31:0] mem_rdata;
    logic        mem_waitrequest;
    logic        err_timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ddr2_port_arbiter dut (
        .ctrl_clk        (clk),
        .reset           (reset),
        .wr_req          (wr_req),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_done         (wr_done),
        .rd_req          (rd_req),
        .rd_addr         (rd_addr),
        .rd_urgent       (rd_urgent),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .mem_addr        (mem_addr),
        .mem_write       (mem_write),
        .mem_wdata       (mem_wdata),
        .mem_read        (mem_read),
        .mem_rdata       (mem_rdata),
        .mem_waitrequest (mem_waitrequest),
        .err_timeout     (err_timeout)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int errs;
        int both;
        int nwr;
        int nrd;
        bit seen;
        bit seq[$];

        reset           = 1'b1;
        wr_req          = 1'b0;
        wr_addr         = '0;
        wr_data         = '0;
        rd_req          = 1'b0;
        rd_addr         = '0;
        rd_urgent       = 1'b0;
        mem_rdata       = '0;
        mem_waitrequest = 1'b0;
        do_reset();

        check("rst_mwr", {31'd0, mem_write}, 0);
        check("rst_mrd", {31'd0, mem_read}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_err", {31'd0, err_timeout}, 0);

        // single write, no stall
        wr_req  = 1'b1;
        wr_addr = 32'h10;
        wr_data = 32'hA5A5A5A5;
        step();
        check("w_mwr", {31'd0, mem_write}, 1);
        check("w_addr", mem_addr, 32'h10);
        check("w_data", mem_wdata, 32'hA5A5A5A5);
        check("w_done0", {31'd0, wr_done}, 0);
        step();
        check("w_mwr_off", {31'd0, mem_write}, 0);
        check("w_done", {31'd0, wr_done}, 1);
        wr_req = 1'b0;
        step();
        check("w_done_pulse", {31'd0, wr_done}, 0);

        // read with 3 stall cycles
        rd_req          = 1'b1;
        rd_addr         = 32'h20;
        mem_rdata       = 32'h12345678;
        mem_waitrequest = 1'b1;
        step();
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_read && mem_addr == 32'h20 && !rd_valid)
                n++;
            if (i == 3)
                mem_waitrequest = 1'b0;
            step();
        end
        check("r_hold", n, 4);
        check("r_valid", {31'd0, rd_valid}, 1);
        check("r_data", rd_data, 32'h12345678);
        check("r_mrd_off", {31'd0, mem_read}, 0);
        rd_req    = 1'b0;
        mem_rdata = 32'hDEADBEEF;
        step();
        check("r_valid_pulse", {31'd0, rd_valid}, 0);
        check("r_data_hold", rd_data, 32'h12345678);

        // both held, no urgency: blocks of 16
        do_reset();
        wr_req = 1'b1;
        rd_req = 1'b1;
        both   = 0;
        for (int i = 0; i < 130; i++) begin
            step();
            if (mem_write && mem_read)
                both++;
            if (mem_write)
                seq.push_back(1'b0);
            if (mem_read)
                seq.push_back(1'b1);
        end
        check("alt_both", both, 0);
        check("alt_count", {31'd0, seq.size() >= 64}, 1);
        errs = 0;
        for (int k = 0; k < 64 && k < seq.size(); k++) begin
            if (seq[k] != bit'((k / 16) % 2))
                errs++;
        end
        check("alt_seq", errs, 0);

        // both held, urgent read
        do_reset();
        wr_req    = 1'b1;
        rd_req    = 1'b1;
        rd_urgent = 1'b1;
        nwr = 0;
        nrd = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (mem_write)
                nwr++;
            if (mem_read)
                nrd++;
        end
        check("urg_wr", nwr, 0);
        check("urg_rd", nrd, 20);
        rd_urgent = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            step();
            if (mem_write)
                seen = 1'b1;
        end
        check("urg_release", {31'd0, seen}, 1);
        wr_req = 1'b0;
        rd_req = 1'b0;
        step();
        step();

        // stuck waitrequest on a read
        do_reset();
        rd_req          = 1'b1;
        rd_addr         = 32'h40;
        mem_waitrequest = 1'b1;
        step();
        n    = 0;
        seen = 1'b0;
        while (mem_read && n < 1100) begin
            n++;
            step();
            if (rd_valid)
                seen = 1'b1;
        end
        check("to_len", n, 1023);
        check("to_err", {31'd0, err_timeout}, 1);
        check("to_novalid", {31'd0, seen}, 0);
        step();
        check("to_rearb", {31'd0, mem_read}, 1);
        mem_waitrequest = 1'b0;
        step();
        check("to_rd_ok", {31'd0, rd_valid}, 1);
        rd_req = 1'b0;
        step();
        check("to_sticky", {31'd0, err_timeout}, 1);

        // reset during a stalled write
        wr_req          = 1'b1;
        wr_addr         = 32'h80;
        wr_data         = 32'h55AA55AA;
        mem_waitrequest = 1'b1;
        step();
        step();
        check("rw_mwr", {31'd0, mem_write}, 1);
        reset = 1'b1;
        step();
        check("rw_mwr_off", {31'd0, mem_write}, 0);
        check("rw_done", {31'd0, wr_done}, 0);
        check("rw_err", {31'd0, err_timeout}, 0);
        check("rw_addr", mem_addr, 0);
        check("rw_wdata", mem_wdata, 0);
        check("rw_rdata", rd_data, 0);
        reset           = 1'b0;
        wr_req          = 1'b0;
        mem_waitrequest = 1'b0;
        step();
        check("rw_no_done", {31'd0, wr_done}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
